// File: rtl/entropy_pool_pkg.sv
// Shared constants and the pool fold step for the entropy pool.
// Consumers: entropy_fifo, entropy_pool.
package entropy_pkg;

  localparam int          WORD_W       = 32;
  localparam int          RAW_W        = 8;
  localparam logic [31:0] CRC_POLY     = 32'h04C11DB7;
  localparam logic [31:0] DEFAULT_SEED = 32'h6A09E667;

  // One CRC-style shift of the pool with the raw byte xored into the low bits.
  function automatic logic [WORD_W-1:0] fold(input logic [WORD_W-1:0] pool,
                                             input logic [RAW_W-1:0]  raw);
    return {pool[WORD_W-2:0], 1'b0}
         ^ (pool[WORD_W-1] ? CRC_POLY : '0)
         ^ {{(WORD_W-RAW_W){1'b0}}, raw};
  endfunction

endpackage

// File: rtl/entropy_pool_fifo.sv
// entropy_fifo: synchronous FIFO with push, pop, flush, full and empty.
// A pop frees its slot before a same-cycle push, so push on full is accepted
// when a pop happens in that cycle. Flush empties the FIFO and wins over both.
module entropy_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  input  logic             i_flush,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int             AW       = $clog2(DEPTH);
  localparam logic [AW:0]    FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_pop;
  logic             w_do_push;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == FULL_CNT);
  assign o_data    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // Storage, pointers and occupancy; flush discards all contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
      else if (!w_do_push && w_do_pop) r_count <= r_count - 1'b1;
    end
  end

endmodule

// File: rtl/entropy_pool.sv
// entropy_pool: folds raw ring-oscillator bytes into a 32-bit CRC-style pool,
// emits one word per SAMPLES enabled bytes through a small FIFO, and runs a
// repetition-count health test when ENTROPY_POOL_HEALTH_EN is defined.
// Output handshake: out_data is the FIFO head and is valid while out_valid=1;
// a word transfers on any edge where out_valid && out_ready, and out_data is
// held stable while out_valid=1 and out_ready=0.
module entropy_pool
  import entropy_pkg::*;
#(
  parameter int          SAMPLES   = 8,
  parameter int          DEPTH     = 4,
  parameter int          REP_LIMIT = 32,
  parameter logic [31:0] SEED      = DEFAULT_SEED
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [RAW_W-1:0]  raw_dat,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              health_fail,
  input  logic              health_clr,
  output logic [7:0]        ovf_cnt
);

  localparam logic [7:0] LAST_CNT = 8'(SAMPLES - 1);

  logic [WORD_W-1:0] r_pool;
  logic [7:0]        r_sample_cnt;
  logic [7:0]        r_ovf_cnt;
  logic [WORD_W-1:0] w_pool_next;
  logic              w_word_done;
  logic              w_trip;
  logic              w_fail;
  logic              w_pop;
  logic              w_push;
  logic              w_drop;
  logic              w_fifo_full;
  logic              w_fifo_empty;

  assign w_pool_next = fold(r_pool, raw_dat);
  assign w_word_done = en && (r_sample_cnt == LAST_CNT);
  assign out_valid   = !w_fifo_empty && !w_fail;
  assign w_pop       = out_valid && out_ready;
  // A word completed on a tripping cycle or while quarantined never reaches the FIFO.
  assign w_push      = w_word_done && !w_trip && !w_fail;
  assign w_drop      = w_push && w_fifo_full && !w_pop;
  assign ovf_cnt     = r_ovf_cnt;
  assign health_fail = w_fail;

  // Pool and sample counter: fold on enable, reseed and realign on a trip.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pool       <= SEED;
      r_sample_cnt <= '0;
    end else if (w_trip) begin
      r_pool       <= SEED;
      r_sample_cnt <= '0;
    end else if (en) begin
      r_pool       <= w_pool_next;
      r_sample_cnt <= (r_sample_cnt == LAST_CNT) ? 8'd0 : r_sample_cnt + 8'd1;
    end
  end

  // Saturating count of completed words lost to a full FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          r_ovf_cnt <= '0;
    else if (w_drop && r_ovf_cnt != 8'hFF) r_ovf_cnt <= r_ovf_cnt + 8'd1;
  end

`ifdef ENTROPY_POOL_HEALTH_EN
  localparam logic [7:0] REP_MAX = 8'(REP_LIMIT);

  logic [RAW_W-1:0] r_last_raw;
  logic [7:0]       r_rep_cnt;
  logic             r_health_fail;
  logic [7:0]       w_rep_next;

  // Next repetition count, saturating at the limit.
  always_comb begin
    w_rep_next = 8'd1;
    if (raw_dat == r_last_raw)
      w_rep_next = (r_rep_cnt >= REP_MAX) ? REP_MAX : r_rep_cnt + 8'd1;
  end

  // Trip only on the cycle the count first reaches the limit.
  assign w_trip = en && (w_rep_next == REP_MAX) && (r_rep_cnt != REP_MAX);
  assign w_fail = r_health_fail;

  // Repetition tracking and sticky failure flag; a trip beats a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_raw    <= '0;
      r_rep_cnt     <= 8'd1;
      r_health_fail <= 1'b0;
    end else begin
      if (en) begin
        r_last_raw <= raw_dat;
        r_rep_cnt  <= w_rep_next;
      end
      if (health_clr && !w_trip) r_rep_cnt <= 8'd1;
      if (w_trip)                r_health_fail <= 1'b1;
      else if (health_clr)       r_health_fail <= 1'b0;
    end
  end
`else
  logic w_unused_health_clr;
  assign w_unused_health_clr = health_clr;
  assign w_trip = 1'b0;
  assign w_fail = 1'b0;
`endif

  entropy_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WORD_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (w_pool_next),
    .i_pop   (w_pop),
    .i_flush (w_trip),
    .o_data  (out_data),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

endmodule

// File: tb/tb_entropy_pool.sv
// Self-checking bench for entropy_pool. Inputs change on the falling edge and
// outputs are sampled 1ns later, half a cycle away from the active edge.
module tb_entropy_pool;

  localparam int          SAMPLES   = 4;
  localparam int          DEPTH     = 4;
  localparam int          REP_LIMIT = 32;
  localparam logic [31:0] SEED      = 32'h6A09E667;
`ifdef ENTROPY_POOL_HEALTH_EN
  localparam bit HEALTH = 1'b1;
`else
  localparam bit HEALTH = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [7:0]  raw_dat = 8'h00;
  logic        out_ready = 1'b0;
  logic        health_clr = 1'b0;
  logic [31:0] out_data;
  logic        out_valid;
  logic        health_fail;
  logic [7:0]  ovf_cnt;

  always #5 clk = ~clk;

  entropy_pool #(
    .SAMPLES   (SAMPLES),
    .DEPTH     (DEPTH),
    .REP_LIMIT (REP_LIMIT),
    .SEED      (SEED)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .raw_dat     (raw_dat),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .health_fail (health_fail),
    .health_clr  (health_clr),
    .ovf_cnt     (ovf_cnt)
  );

  // ---------------- scoreboard and reference model ----------------
  logic [31:0] exp_q[$];   // model of the FIFO contents, head first
  logic [31:0] m_pool;
  int          m_cnt;
  int          m_rep;
  logic [7:0]  m_last;
  bit          m_fail;
  int          m_ovf;
  int          n_vec = 0;
  int          n_err = 0;

  function automatic logic [31:0] ref_fold(input logic [31:0] p, input logic [7:0] r);
    logic [31:0] t;
    t = p << 1;
    if (p[31]) t = t ^ 32'h04C11DB7;
    t[7:0] = t[7:0] ^ r;
    return t;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_pool = SEED;
    m_cnt  = 0;
    m_rep  = 1;
    m_last = 8'h00;
    m_fail = 1'b0;
    m_ovf  = 0;
  endtask

  // One clock: drive inputs, check outputs against the model, pop the
  // scoreboard on a handshake, then advance the model across the edge.
  task automatic cycle(input bit e, input logic [7:0] r, input bit rdy, input bit c);
    logic [31:0] nxt;
    logic [31:0] exp_w;
    int          rep_n;
    bit          trip;
    bit          exp_valid;
    en = e; raw_dat = r; out_ready = rdy; health_clr = c;
    #1;
    exp_valid = (exp_q.size() != 0) && !m_fail;
    n_vec++;
    if (out_valid !== exp_valid) begin
      n_err++;
      $display("FAIL out_valid @%0t: got %b expected %b", $time, out_valid, exp_valid);
    end
    n_vec++;
    if (health_fail !== m_fail) begin
      n_err++;
      $display("FAIL health_fail @%0t: got %b expected %b", $time, health_fail, m_fail);
    end
    n_vec++;
    if (ovf_cnt !== 8'(m_ovf)) begin
      n_err++;
      $display("FAIL ovf_cnt @%0t: got %0d expected %0d", $time, ovf_cnt, m_ovf);
    end
    if (exp_valid && rdy) begin
      exp_w = exp_q.pop_front();
      n_vec++;
      if (out_data !== exp_w) begin
        n_err++;
        $display("FAIL out_data @%0t: got %h expected %h", $time, out_data, exp_w);
      end
    end
    trip = 1'b0;
    if (e) begin
      nxt   = ref_fold(m_pool, r);
      rep_n = (r == m_last) ? ((m_rep >= REP_LIMIT) ? REP_LIMIT : m_rep + 1) : 1;
      trip  = HEALTH && (rep_n == REP_LIMIT) && (m_rep != REP_LIMIT);
      if (trip) begin
        exp_q.delete();
        m_pool = SEED;
        m_cnt  = 0;
        m_fail = 1'b1;
      end else begin
        if (m_cnt == SAMPLES - 1 && !m_fail) begin
          if (exp_q.size() < DEPTH) exp_q.push_back(nxt);
          else if (m_ovf < 255)     m_ovf++;
        end
        m_pool = nxt;
        m_cnt  = (m_cnt == SAMPLES - 1) ? 0 : m_cnt + 1;
      end
      m_last = r;
      m_rep  = rep_n;
    end
    if (c && !trip) begin
      m_fail = 1'b0;
      m_rep  = 1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; en = 1'b0; raw_dat = 8'h00; out_ready = 1'b0; health_clr = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [7:0] rnd_byte();
    return 8'($urandom_range(0, 255));
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    apply_reset();
    #1;
    n_vec++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    n_vec++;
    if (out_data !== 32'h0) begin n_err++; $display("FAIL reset_data: got %h expected 00000000", out_data); end
    n_vec++;
    if (health_fail !== 1'b0) begin n_err++; $display("FAIL reset_health: got %b expected 0", health_fail); end
    n_vec++;
    if (ovf_cnt !== 8'h00) begin n_err++; $display("FAIL reset_ovf: got %h expected 00", ovf_cnt); end
    @(negedge clk);
  endtask

  task automatic test_first_word();
    logic [7:0]  seq [4];
    logic [31:0] w;
    seq[0] = 8'h01; seq[1] = 8'h00; seq[2] = 8'h00; seq[3] = 8'h00;
    w = SEED;
    for (int i = 0; i < 4; i++) w = ref_fold(w, seq[i]);
    for (int i = 0; i < 3; i++) cycle(1'b1, seq[i], 1'b0, 1'b0);
    #1;
    n_vec++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL early_valid: got %b expected 0", out_valid); end
    cycle(1'b1, seq[3], 1'b0, 1'b0);
    #1;
    n_vec++;
    if (out_valid !== 1'b1) begin n_err++; $display("FAIL word_latency: got %b expected 1", out_valid); end
    n_vec++;
    if (out_data !== w) begin n_err++; $display("FAIL first_word: got %h expected %h", out_data, w); end
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_en_hold();
    cycle(1'b1, rnd_byte(), 1'b1, 1'b0);
    cycle(1'b1, rnd_byte(), 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b0, rnd_byte(), 1'b0, 1'b0);
    cycle(1'b1, rnd_byte(), 1'b0, 1'b0);
    #1;
    n_vec++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL en_hold_early: got %b expected 0", out_valid); end
    cycle(1'b1, rnd_byte(), 1'b0, 1'b0);
    #1;
    n_vec++;
    if (out_valid !== 1'b1) begin n_err++; $display("FAIL en_hold_done: got %b expected 1", out_valid); end
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_overflow();
    apply_reset();
    for (int i = 0; i < DEPTH * SAMPLES; i++) cycle(1'b1, rnd_byte(), 1'b0, 1'b0);
    #1;
    n_vec++;
    if (ovf_cnt !== 8'd0) begin n_err++; $display("FAIL ovf_at_full: got %0d expected 0", ovf_cnt); end
    for (int i = 0; i < 3 * SAMPLES; i++) cycle(1'b1, rnd_byte(), 1'b0, 1'b0);
    #1;
    n_vec++;
    if (ovf_cnt !== 8'd3) begin n_err++; $display("FAIL ovf_three: got %0d expected 3", ovf_cnt); end
    // Pop in the same cycle the next word completes on a full FIFO.
    for (int i = 0; i < SAMPLES - 1; i++) cycle(1'b1, rnd_byte(), 1'b0, 1'b0);
    cycle(1'b1, rnd_byte(), 1'b1, 1'b0);
    #1;
    n_vec++;
    if (ovf_cnt !== 8'd3) begin n_err++; $display("FAIL full_push_pop: got %0d expected 3", ovf_cnt); end
    for (int i = 0; i < 260 * SAMPLES; i++) cycle(1'b1, rnd_byte(), 1'b0, 1'b0);
    #1;
    n_vec++;
    if (ovf_cnt !== 8'hFF) begin n_err++; $display("FAIL ovf_saturate: got %0d expected 255", ovf_cnt); end
    for (int i = 0; i < DEPTH + 2; i++) cycle(1'b0, rnd_byte(), 1'b1, 1'b0);
    #1;
    n_vec++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL drain_empty: got %b expected 0", out_valid); end
  endtask

  task automatic test_health();
    apply_reset();
`ifdef ENTROPY_POOL_HEALTH_EN
    for (int i = 0; i < SAMPLES; i++) cycle(1'b1, rnd_byte(), 1'b0, 1'b0);
    cycle(1'b1, 8'h11, 1'b0, 1'b0);
    for (int i = 0; i < REP_LIMIT - 1; i++) cycle(1'b1, 8'h5A, 1'b0, 1'b0);
    #1;
    n_vec++;
    if (health_fail !== 1'b0) begin n_err++; $display("FAIL pre_trip: got %b expected 0", health_fail); end
    n_vec++;
    if (out_valid !== 1'b1) begin n_err++; $display("FAIL pre_trip_valid: got %b expected 1", out_valid); end
    cycle(1'b1, 8'h5A, 1'b0, 1'b0);
    #1;
    n_vec++;
    if (health_fail !== 1'b1) begin n_err++; $display("FAIL trip: got %b expected 1", health_fail); end
    n_vec++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL trip_valid: got %b expected 0", out_valid); end
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'h5A, 1'b1, 1'b0);
    cycle(1'b1, 8'h33, 1'b0, 1'b1);
    #1;
    n_vec++;
    if (health_fail !== 1'b0) begin n_err++; $display("FAIL clear: got %b expected 0", health_fail); end
    for (int i = 0; i < 2 * SAMPLES; i++) cycle(1'b1, rnd_byte(), 1'b0, 1'b0);
    #1;
    n_vec++;
    if (out_valid !== 1'b1) begin n_err++; $display("FAIL resume_valid: got %b expected 1", out_valid); end
    cycle(1'b1, 8'h44, 1'b0, 1'b0);
    for (int i = 0; i < REP_LIMIT - 1; i++) cycle(1'b1, 8'h5A, 1'b0, 1'b0);
    cycle(1'b1, 8'h5A, 1'b0, 1'b1);
    #1;
    n_vec++;
    if (health_fail !== 1'b1) begin n_err++; $display("FAIL trip_beats_clr: got %b expected 1", health_fail); end
    cycle(1'b1, 8'h44, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) cycle(1'b1, rnd_byte(), 1'b1, 1'b0);
`else
    for (int i = 0; i < REP_LIMIT + 8; i++) cycle(1'b1, 8'h5A, 1'b0, 1'b0);
    #1;
    n_vec++;
    if (health_fail !== 1'b0) begin n_err++; $display("FAIL no_health_flag: got %b expected 0", health_fail); end
    n_vec++;
    if (out_valid !== 1'b1) begin n_err++; $display("FAIL no_health_valid: got %b expected 1", out_valid); end
    cycle(1'b0, 8'h5A, 1'b1, 1'b1);
    cycle(1'b0, 8'h5A, 1'b1, 1'b0);
`endif
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int i = 0; i < SAMPLES + 2; i++) cycle(1'b1, rnd_byte(), 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL async_valid: got %b expected 0", out_valid); end
    n_vec++;
    if (out_data !== 32'h0) begin n_err++; $display("FAIL async_data: got %h expected 00000000", out_data); end
    model_reset();
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < SAMPLES - 1; i++) cycle(1'b1, rnd_byte(), 1'b0, 1'b0);
    #1;
    n_vec++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL partial_abandon: got %b expected 0", out_valid); end
    cycle(1'b1, rnd_byte(), 1'b0, 1'b0);
    #1;
    n_vec++;
    if (out_valid !== 1'b1) begin n_err++; $display("FAIL post_reset_word: got %b expected 1", out_valid); end
    // Reset while a repetition run is in progress restarts the count.
    for (int i = 0; i < REP_LIMIT - 12; i++) cycle(1'b1, 8'h5A, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    model_reset();
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < REP_LIMIT - 1; i++) cycle(1'b1, 8'h5A, 1'b1, 1'b0);
    #1;
    n_vec++;
    if (health_fail !== 1'b0) begin n_err++; $display("FAIL rep_restart: got %b expected 0", health_fail); end
    for (int i = 0; i < 3; i++) cycle(1'b1, rnd_byte(), 1'b1, 1'b0);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_first_word();
    test_en_hold();
    test_overflow();
    test_health();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
